// File: rtl/col_decoder_3b_if.sv
// Encoded-word input and decoded-pixel output handshakes
// of the 3-bit column pixel decoder.
interface col_decoder_3b_if;
    logic [15:0] encoded_dat;
    logic        enc_valid;
    logic        enc_ready;
    logic [2:0]  pixel_out;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        fmt_err;

    modport master (
        output encoded_dat,
        output enc_valid,
        output pixel_ready,
        input  enc_ready,
        input  pixel_out,
        input  pixel_valid,
        input  fmt_err
    );

    modport slave (
        input  encoded_dat,
        input  enc_valid,
        input  pixel_ready,
        output enc_ready,
        output pixel_out,
        output pixel_valid,
        output fmt_err
    );
endinterface

// File: rtl/col_decoder_3b.sv
// Column pixel decoder: expands 16-bit run/literal words into 3-bit pixels.
// Optional macro COL_DEC_CHK_EN enables the sticky reserved-bit error flag.
module col_decoder_3b #(
    parameter int RUN_W = 15
) (
    input logic             clk,
    input logic             rst_n,
    col_decoder_3b_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        LIT,
        RUN
    } state_t;

    localparam logic [RUN_W-1:0] REM_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [RUN_W-1:0] rem_q, rem_d;
    logic [11:0]      shift_q, shift_d;
    logic [2:0]       pix_q, pix_d;
    logic             vld_q, vld_d;

    logic             last;
    logic             ready;
    logic             accept;
    logic             advance;

    // Handshake terms; enc_ready never depends on enc_valid.
    always_comb begin
        last    = (rem_q == '0);
        ready   = !vld_q | (bus.pixel_ready & last);
        accept  = bus.enc_valid & ready;
        advance = vld_q & bus.pixel_ready;
    end

    // Next-state: load a new word, step within a word, or go idle.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        pix_d   = pix_q;
        vld_d   = vld_q;
        if (accept) begin
            vld_d = 1'b1;
            if (bus.encoded_dat[15]) begin
                state_d = RUN;
                pix_d   = 3'd0;
                rem_d   = bus.encoded_dat[RUN_W-1:0];
            end else begin
                state_d = LIT;
                pix_d   = bus.encoded_dat[2:0];
                shift_d = {3'd0, bus.encoded_dat[11:3]};
                rem_d   = {{(RUN_W-2){1'b0}}, bus.encoded_dat[13:12]};
            end
        end else if (advance) begin
            if (!last) begin
                rem_d = rem_q - REM_ONE;
                unique case (state_q)
                    LIT: begin
                        pix_d   = shift_q[2:0];
                        shift_d = {3'd0, shift_q[11:3]};
                    end
                    RUN:     pix_d = 3'd0;
                    default: pix_d = pix_q;
                endcase
            end else begin
                vld_d   = 1'b0;
                state_d = IDLE;
            end
        end
    end

    // Decoder state and registered pixel output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            shift_q <= '0;
            pix_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            shift_q <= shift_d;
            pix_q   <= pix_d;
            vld_q   <= vld_d;
        end
    end

`ifdef COL_DEC_CHK_EN
    logic err_q;

    // Sticky flag: a literal word arrived with reserved bit14 set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept & !bus.encoded_dat[15] & bus.encoded_dat[14]) begin
            err_q <= 1'b1;
        end
    end

    assign bus.fmt_err = err_q;
`else
    assign bus.fmt_err = 1'b0;
`endif

    assign bus.enc_ready   = ready;
    assign bus.pixel_out   = pix_q;
    assign bus.pixel_valid = vld_q;

endmodule
